// File: rtl/uart_frame_tx_if.sv
// rtl/uart_frame_tx_if.sv - request/status bundle between the command sequencer and uart_frame_tx
interface uart_frame_tx_if #(
   parameter int MAX_BYTES = 16,
   parameter int NUM_CH    = 2
);
   localparam int LW = $clog2(MAX_BYTES + 1);

   logic                   start;
   logic [MAX_BYTES*8-1:0] frame_data;
   logic [LW-1:0]          frame_len;
   logic [NUM_CH-1:0]      ch_mask;
   logic [NUM_CH-1:0]      uart_txd;
   logic                   busy;
   logic                   trans_done;
   logic                   err_len;

   modport master (
      output start, frame_data, frame_len, ch_mask,
      input  uart_txd, busy, trans_done, err_len
   );

   modport slave (
      input  start, frame_data, frame_len, ch_mask,
      output uart_txd, busy, trans_done, err_len
   );
endinterface

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - multi-byte UART frame sender with mirrored, per-line gated TX outputs
module uart_frame_tx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int UART_BPS  = 9600,
   parameter int MAX_BYTES = 16,
   parameter int NUM_CH    = 2,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   uart_frame_tx_if.slave   bus
);
   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int CW      = $clog2(BPS_CNT);
   localparam int LW      = $clog2(MAX_BYTES + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          baud_cnt_q, baud_cnt_d;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic [LW-1:0]          byte_idx_q, byte_idx_d;
   logic [LW-1:0]          len_q, len_d;
   logic [MAX_BYTES*8-1:0] data_q, data_d;
   logic [NUM_CH-1:0]      mask_q, mask_d;
   logic [NUM_CH-1:0]      txd_q, txd_d;
   logic                   start_prev_q, start_prev_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic                   start_edge;
   logic                   baud_wrap;
   logic                   len_ok;
   logic [7:0]             cur_byte;
   logic                   serial;

   always_comb begin
      state_d      = state_q;
      baud_cnt_d   = baud_cnt_q;
      bit_idx_d    = bit_idx_q;
      byte_idx_d   = byte_idx_q;
      len_d        = len_q;
      data_d       = data_q;
      mask_d       = mask_q;
      start_prev_d = bus.start;
      done_d       = 1'b0;
      err_d        = 1'b0;
      serial       = 1'b1;
      start_edge   = bus.start & ~start_prev_q;
      baud_wrap    = (baud_cnt_q == CW'(BPS_CNT - 1));
      len_ok       = (bus.frame_len != '0) && (bus.frame_len <= LW'(MAX_BYTES));

      if (state_q == IDLE) begin
         if (start_edge) begin
            if (len_ok) begin
               state_d    = START;
               data_d     = bus.frame_data;
               len_d      = bus.frame_len;
               mask_d     = bus.ch_mask;
               byte_idx_d = '0;
               bit_idx_d  = '0;
               baud_cnt_d = '0;
            end else begin
               err_d = 1'b1;
            end
         end
      end else begin
         baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + CW'(1);
         if (baud_wrap) begin
            case (state_q)
               START: begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end
               DATA: begin
                  if (bit_idx_q == 3'd7) begin
                     state_d   = (PARITY != 0) ? PAR : STOP;
                     bit_idx_d = '0;
                  end else begin
                     bit_idx_d = bit_idx_q + 3'd1;
                  end
               end
               PAR: begin
                  state_d   = STOP;
                  bit_idx_d = '0;
               end
               STOP: begin
                  if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                     bit_idx_d = '0;
                     // Chain straight into the next start bit so multi-byte frames have no idle gap.
                     if ((byte_idx_q + LW'(1)) < len_q) begin
                        byte_idx_d = byte_idx_q + LW'(1);
                        state_d    = START;
                     end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end
                  end else begin
                     bit_idx_d = bit_idx_q + 3'd1;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end

      // The line value is derived from next-state so the registered output lines up with the state.
      cur_byte = data_d[{byte_idx_d, 3'b000} +: 8];
      case (state_d)
         START:   serial = 1'b0;
         DATA:    serial = cur_byte[bit_idx_d];
         PAR:     serial = (PARITY == 1) ? ~^cur_byte : ^cur_byte;
         default: serial = 1'b1;
      endcase
      txd_d = {NUM_CH{serial}} | ~mask_d;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= IDLE;
         baud_cnt_q   <= '0;
         bit_idx_q    <= '0;
         byte_idx_q   <= '0;
         len_q        <= '0;
         data_q       <= '0;
         mask_q       <= '0;
         txd_q        <= '1;
         start_prev_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         baud_cnt_q   <= baud_cnt_d;
         bit_idx_q    <= bit_idx_d;
         byte_idx_q   <= byte_idx_d;
         len_q        <= len_d;
         data_q       <= data_d;
         mask_q       <= mask_d;
         txd_q        <= txd_d;
         start_prev_q <= start_prev_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign bus.uart_txd   = txd_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.trans_done = done_q;
   assign bus.err_len    = err_q;
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb/tb_uart_frame_tx.sv - bench for uart_frame_tx: no-parity, even/2-stop and odd-parity instances vs a bit-list model
module tb_uart_frame_tx;
   localparam int BPS = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [2:0]   start_v = '0;
   logic [127:0] frame_data = '0;
   logic [4:0]   frame_len = 5'd1;
   logic [1:0]   ch_mask = 2'b11;
   int           total = 0;
   int           bad = 0;
   int           par_cfg [3] = '{0, 2, 1};
   int           stop_cfg[3] = '{1, 2, 1};

   always #5 clk = ~clk;

   uart_frame_tx_if #(.MAX_BYTES(16), .NUM_CH(2)) ifa ();
   uart_frame_tx_if #(.MAX_BYTES(16), .NUM_CH(2)) ifb ();
   uart_frame_tx_if #(.MAX_BYTES(16), .NUM_CH(2)) ifc ();

   assign ifa.start = start_v[0];
   assign ifb.start = start_v[1];
   assign ifc.start = start_v[2];
   assign ifa.frame_data = frame_data;
   assign ifb.frame_data = frame_data;
   assign ifc.frame_data = frame_data;
   assign ifa.frame_len = frame_len;
   assign ifb.frame_len = frame_len;
   assign ifc.frame_len = frame_len;
   assign ifa.ch_mask = ch_mask;
   assign ifb.ch_mask = ch_mask;
   assign ifc.ch_mask = ch_mask;

   uart_frame_tx #(.CLK_FREQ(1000000), .UART_BPS(100000), .MAX_BYTES(16), .NUM_CH(2),
                   .PARITY(0), .STOP_BITS(1)) dut_a (.sys_clk(clk), .sys_rst(rst), .bus(ifa));
   uart_frame_tx #(.CLK_FREQ(1000000), .UART_BPS(100000), .MAX_BYTES(16), .NUM_CH(2),
                   .PARITY(2), .STOP_BITS(2)) dut_b (.sys_clk(clk), .sys_rst(rst), .bus(ifb));
   uart_frame_tx #(.CLK_FREQ(1000000), .UART_BPS(100000), .MAX_BYTES(16), .NUM_CH(2),
                   .PARITY(1), .STOP_BITS(1)) dut_c (.sys_clk(clk), .sys_rst(rst), .bus(ifc));

   function automatic logic [4:0] obs(input int s);
      case (s)
         0:       return {ifa.uart_txd, ifa.busy, ifa.trans_done, ifa.err_len};
         1:       return {ifb.uart_txd, ifb.busy, ifb.trans_done, ifb.err_len};
         default: return {ifc.uart_txd, ifc.busy, ifc.trans_done, ifc.err_len};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed={txd,busy,done,err}=%b expected=%b", tag, o, e);
      end
   endtask

   // Called at a negedge with start low; returns at the negedge of the trans_done cycle.
   task automatic run_frame(input int s, input string tag, input int len,
                            input logic [127:0] data, input logic [1:0] mask);
      bit         q[$];
      logic [7:0] b;
      logic       bt;
      int         n;
      for (int j = 0; j < len; j++) begin
         b = data[8*j +: 8];
         q.push_back(1'b0);
         for (int i = 0; i < 8; i++) q.push_back(b[i]);
         n = $countones(b);
         if (par_cfg[s] == 1) q.push_back((n % 2) == 0);
         if (par_cfg[s] == 2) q.push_back((n % 2) == 1);
         for (int i = 0; i < stop_cfg[s]; i++) q.push_back(1'b1);
      end
      frame_data = data;
      frame_len  = 5'(len);
      ch_mask    = mask;
      start_v[s] = 1'b1;
      for (int k = 0; k < q.size() * BPS; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start_v[s] = 1'b0;
            frame_data = {$urandom, $urandom, $urandom, $urandom};
            frame_len  = 5'($urandom);
            ch_mask    = 2'($urandom);
         end
         if (k == 30) start_v[s] = 1'b1;
         if (k == 31) start_v[s] = 1'b0;
         bt = q[k / BPS];
         chk(tag, obs(s), {({2{bt}} | ~mask), 3'b100});
      end
      @(negedge clk);
      chk({tag, "_done"}, obs(s), 5'b11010);
   endtask

   initial begin
      string            cmd;
      logic [127:0]     d;
      int               ln;

      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) chk("reset_state", obs(s), 5'b11000);
      rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 3; s++) chk("post_reset_idle", obs(s), 5'b11000);

      run_frame(0, "byte_55", 1, 128'h55, 2'b11);
      repeat (3) @(negedge clk);

      cmd = "#000P1500T1000!";
      d = '0;
      for (int k = 0; k < 15; k++) d[8*k +: 8] = cmd[k];
      run_frame(0, "servo_cmd", 15, d, 2'b01);
      repeat (3) @(negedge clk);

      run_frame(1, "even_par_07", 1, 128'h07, 2'b11);
      repeat (3) @(negedge clk);
      run_frame(2, "odd_par_07", 1, 128'h07, 2'b10);
      repeat (3) @(negedge clk);

      frame_len  = 5'd0;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      chk("err_len_0", obs(0), 5'b11001);
      @(negedge clk);
      chk("err_len_0_clear", obs(0), 5'b11000);
      frame_len  = 5'd17;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      chk("err_len_17", obs(0), 5'b11001);
      @(negedge clk);
      chk("err_len_17_clear", obs(0), 5'b11000);

      frame_data = {$urandom, $urandom, $urandom, $urandom};
      frame_len  = 5'd3;
      ch_mask    = 2'b11;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      chk("abort_start_bit", obs(0), 5'b00100);
      repeat (19) @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (99) @(negedge clk);
      chk("abort_still_busy", obs(0) & 5'b00111, 5'b00100);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_reset", obs(0), 5'b11000);
      repeat (40) begin
         @(negedge clk);
         chk("abort_quiet", obs(0), 5'b11000);
      end

      run_frame(0, "after_abort", 3, {$urandom, $urandom, $urandom, $urandom}, 2'b11);
      run_frame(0, "chained", 2, {$urandom, $urandom, $urandom, $urandom}, 2'b10);
      repeat (3) @(negedge clk);

      run_frame(2, "max_len_16", 16, {$urandom, $urandom, $urandom, $urandom}, 2'b11);
      repeat (3) @(negedge clk);
      run_frame(1, "mask_zero", 2, {$urandom, $urandom, $urandom, $urandom}, 2'b00);
      repeat (3) @(negedge clk);

      for (int r = 0; r < 6; r++) begin
         d  = {$urandom, $urandom, $urandom, $urandom};
         ln = $urandom_range(1, 4);
         run_frame(r % 3, "random", ln, d, 2'($urandom));
         repeat ($urandom_range(1, 4)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
